// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-fill, D-fill and D-writeback requests.
// One transaction in flight; round-robin between fills, writeback always first.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_rvalid,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_rd_addr,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_wdone,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_rd_addr,
  output logic [ADDR_W-1:0] m_wr_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_rvalid,
  input  logic              m_wdone
);
  typedef enum logic [1:0] {IDLE, D_WB, D_FILL, I_FILL} state_t;
  state_t state, nxt;
  logic last_d;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [LINE_W-1:0] wdata_q;
  always_comb begin
    nxt = state;
    m_read = 1'b0;
    m_write = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    d_wdone = 1'b0;
    case (state)
      IDLE: nxt = d_write ? D_WB :
                  (d_read && i_read) ? (last_d ? I_FILL : D_FILL) :
                  d_read ? D_FILL : i_read ? I_FILL : IDLE;
      D_WB: begin
        m_write = 1'b1;
        d_wdone = m_wdone;
        nxt = m_wdone ? (d_read ? D_FILL : IDLE) : D_WB;
      end
      D_FILL: begin
        m_read = 1'b1;
        d_rvalid = m_rvalid;
        nxt = m_rvalid ? IDLE : D_FILL;
      end
      default: begin
        m_read = 1'b1;
        i_rvalid = m_rvalid;
        nxt = m_rvalid ? IDLE : I_FILL;
      end
    endcase
  end
  // capture request operands only on entry to a grant state so later request changes are ignored
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last_d <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= nxt;
      if (nxt == D_WB && state != D_WB) begin
        wr_addr_q <= d_wr_addr;
        wdata_q <= d_wdata;
      end
      if (nxt != state && (nxt == D_FILL || nxt == I_FILL))
        rd_addr_q <= (nxt == D_FILL) ? d_rd_addr : i_addr;
      if (m_rvalid && (state == D_FILL || state == I_FILL))
        last_d <= (state == D_FILL);
    end
  end
  assign m_rd_addr = rd_addr_q;
  assign m_wr_addr = wr_addr_q;
  assign m_wdata = wdata_q;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
endmodule
